ifu_fetch_ctrl: RTL and testbench

Multi-cycle instruction-fetch controller that replaces the combinational DPI fetch at the front of the NPC core. It owns the architectural PC and issues one read per instruction on an AXI-lite-style AR/R channel. It presents the fetched word to the decode stage over a valid/ready handshake, then waits for writeback to return the next PC (`dnpc`) before fetching again.

---
 rtl/npc_pkg.sv | 24 ++
 rtl/ifu_fetch_ctrl_chk.sv | 25 ++
 rtl/ifu_fetch_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ifu_fetch_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared types and constants for the NPC front end (instruction fetch).
package npc_pkg;

   // Fetch controller states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_REQ    = 3'd1,
      ST_RESP   = 3'd2,
      ST_OUT    = 3'd3,
      ST_WAITWB = 3'd4
   } ifu_state_t;

   // R channel response code for a successful read
   localparam logic [1:0]  RESP_OKAY        = 2'b00;

   // Architectural PC after reset
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

   // A fetch address is misaligned when either of its two low bits is set
   function automatic logic pc_misaligned(input logic [1:0] pc_lsbs);
      return (pc_lsbs != 2'b00);
   endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_chk.sv
// Protocol checker for ifu_fetch_ctrl, attached alongside the controller.
module ifu_fetch_ctrl_chk (
   input logic        clk,
   input logic        rst,
   input logic        ar_valid,
   input logic        ar_ready,
   input logic [31:0] ar_addr,
   input logic        r_valid,
   input logic        r_ready,
   input logic        inst_valid
);

   // An R beat while the address is still pending is a bus protocol violation
   a_no_r_during_req: assert property (@(posedge clk) disable iff (rst)
      r_valid |-> !ar_valid);

   // A stalled AR request must hold valid and address
   a_ar_stable: assert property (@(posedge clk) disable iff (rst)
      (ar_valid && !ar_ready) |=> (ar_valid && $stable(ar_addr)));

   // At most one handshake phase is active at a time
   a_phase_onehot: assert property (@(posedge clk) disable iff (rst)
      $onehot0({ar_valid, r_ready, inst_valid}));

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Multi-cycle instruction fetch controller: owns the PC, issues one AR/R read
// per instruction, hands the word to decode, then waits for writeback's dnpc.
// Misaligned PCs skip the bus entirely and surface as a fetch_err instruction.
module ifu_fetch_ctrl
   import npc_pkg::*;
#(
   parameter logic [31:0] RESET_PC = npc_pkg::DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   input  logic [31:0] dnpc,
   output logic        ar_valid,
   input  logic        ar_ready,
   output logic [31:0] ar_addr,
   input  logic        r_valid,
   output logic        r_ready,
   input  logic [31:0] r_data,
   input  logic [1:0]  r_resp,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        fetch_err
);

   ifu_state_t  state_q;
   ifu_state_t  state_d;
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] inst_q;
   logic [31:0] inst_d;
   logic        fetch_err_q;
   logic        fetch_err_d;

   // State register; reset aborts any transaction straight back to IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // PC and instruction buffer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         inst_q      <= 32'h0000_0000;
         fetch_err_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         inst_q      <= inst_d;
         fetch_err_q <= fetch_err_d;
      end
   end

   // Next-state logic: one bus read per instruction, no prefetch
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (pc_misaligned(pc_q[1:0])) begin
               state_d = ST_OUT;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (ar_ready) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_REQ;
            end
         end
         ST_RESP: begin
            if (r_valid) begin
               state_d = ST_OUT;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_OUT: begin
            if (inst_ready) begin
               state_d = ST_WAITWB;
            end else begin
               state_d = ST_OUT;
            end
         end
         ST_WAITWB: begin
            if (wb_valid) begin
               if (pc_misaligned(dnpc[1:0])) begin
                  state_d = ST_OUT;
               end else begin
                  state_d = ST_REQ;
               end
            end else begin
               state_d = ST_WAITWB;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Datapath updates: capture the R beat, load dnpc, synthesize fault words
   always_comb begin
      pc_d        = pc_q;
      inst_d      = inst_q;
      fetch_err_d = fetch_err_q;
      case (state_q)
         ST_IDLE: begin
            if (pc_misaligned(pc_q[1:0])) begin
               inst_d      = 32'h0000_0000;
               fetch_err_d = 1'b1;
            end else begin
               inst_d      = inst_q;
               fetch_err_d = fetch_err_q;
            end
         end
         ST_RESP: begin
            if (r_valid) begin
               inst_d      = r_data;
               fetch_err_d = (r_resp != RESP_OKAY);
            end else begin
               inst_d      = inst_q;
               fetch_err_d = fetch_err_q;
            end
         end
         ST_WAITWB: begin
            if (wb_valid) begin
               pc_d = dnpc;
               if (pc_misaligned(dnpc[1:0])) begin
                  inst_d      = 32'h0000_0000;
                  fetch_err_d = 1'b1;
               end else begin
                  inst_d      = inst_q;
                  fetch_err_d = fetch_err_q;
               end
            end else begin
               pc_d = pc_q;
            end
         end
         default: begin
            pc_d        = pc_q;
            inst_d      = inst_q;
            fetch_err_d = fetch_err_q;
         end
      endcase
   end

   // Moore handshake outputs decoded from the state register
   always_comb begin
      ar_valid   = 1'b0;
      r_ready    = 1'b0;
      inst_valid = 1'b0;
      case (state_q)
         ST_REQ:  ar_valid   = 1'b1;
         ST_RESP: r_ready    = 1'b1;
         ST_OUT:  inst_valid = 1'b1;
         default: begin
            ar_valid   = 1'b0;
            r_ready    = 1'b0;
            inst_valid = 1'b0;
         end
      endcase
   end

   // The fetch address is the PC itself, so it is stable for the whole AR phase
   assign ar_addr   = pc_q;
   assign pc        = pc_q;
   assign inst      = inst_q;
   assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Scoreboard bench for ifu_fetch_ctrl: expected AR addresses and decoded
// instructions are queued as stimulus is set up and checked at each handshake.
module tb_ifu_fetch_ctrl;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic        err;
   } exp_inst_t;

   logic        clk;
   logic        rst;
   logic        wb_valid;
   logic [31:0] dnpc;
   logic        ar_valid;
   logic        ar_ready;
   logic [31:0] ar_addr;
   logic        r_valid;
   logic        r_ready;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        fetch_err;

   logic        bus_go;
   int          n_vec;
   int          n_err;
   int          ar_hs;
   logic [31:0] exp_ar[$];
   exp_inst_t   exp_inst[$];
   logic [31:0] mon_ar;
   exp_inst_t   mon_inst;

   ifu_fetch_ctrl #(.RESET_PC(32'h8000_0000)) dut (
      .clk        (clk),
      .rst        (rst),
      .wb_valid   (wb_valid),
      .dnpc       (dnpc),
      .ar_valid   (ar_valid),
      .ar_ready   (ar_ready),
      .ar_addr    (ar_addr),
      .r_valid    (r_valid),
      .r_ready    (r_ready),
      .r_data     (r_data),
      .r_resp     (r_resp),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .inst       (inst),
      .pc         (pc),
      .fetch_err  (fetch_err)
   );

   ifu_fetch_ctrl_chk u_chk (
      .clk        (clk),
      .rst        (rst),
      .ar_valid   (ar_valid),
      .ar_ready   (ar_ready),
      .ar_addr    (ar_addr),
      .r_valid    (r_valid),
      .r_ready    (r_ready),
      .inst_valid (inst_valid)
   );

   // Clock generation
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check_val({tag, "_ar_valid"},   {31'd0, ar_valid},   32'd0);
      check_val({tag, "_r_ready"},    {31'd0, r_ready},    32'd0);
      check_val({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
      check_val({tag, "_pc"},         pc,                  32'h8000_0000);
      check_val({tag, "_inst"},       inst,                32'h0000_0000);
      check_val({tag, "_fetch_err"},  {31'd0, fetch_err},  32'd0);
   endtask

   // Zero-wait read responder: answers in the first RESP cycle when enabled
   initial begin
      r_valid = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         r_valid = bus_go && r_ready;
      end
   end

   // Scoreboard: pop and compare at every AR and decode handshake
   always @(negedge clk) begin
      if (!rst) begin
         if (ar_valid && ar_ready) begin
            ar_hs = ar_hs + 1;
            check_val("ar_expected", {31'd0, (exp_ar.size() != 0)}, 32'd1);
            if (exp_ar.size() != 0) begin
               mon_ar = exp_ar.pop_front();
               check_val("sb_ar_addr", ar_addr, mon_ar);
            end
         end
         if (inst_valid && inst_ready) begin
            check_val("inst_expected", {31'd0, (exp_inst.size() != 0)}, 32'd1);
            if (exp_inst.size() != 0) begin
               mon_inst = exp_inst.pop_front();
               check_val("sb_inst", inst, mon_inst.inst);
               check_val("sb_pc", pc, mon_inst.pc);
               check_val("sb_err", {31'd0, fetch_err}, {31'd0, mon_inst.err});
            end
         end
      end
   end

   // Main stimulus sequence
   initial begin
      int waited;
      n_vec      = 0;
      n_err      = 0;
      ar_hs      = 0;
      rst        = 1'b1;
      wb_valid   = 1'b0;
      dnpc       = 32'h0000_0000;
      ar_ready   = 1'b1;
      r_data     = 32'h0000_0413;
      r_resp     = 2'b00;
      inst_ready = 1'b1;
      bus_go     = 1'b1;

      // Reset state
      repeat (3) tick();
      check_reset_values("rst");

      // First fetch with a zero-wait bus
      exp_ar.push_back(32'h8000_0000);
      exp_inst.push_back('{inst: 32'h0000_0413, pc: 32'h8000_0000, err: 1'b0});
      @(negedge clk);
      rst = 1'b0;
      tick();
      check_val("c1_ar_valid", {31'd0, ar_valid}, 32'd1);
      check_val("c1_ar_addr", ar_addr, 32'h8000_0000);
      tick();
      check_val("c2_r_ready", {31'd0, r_ready}, 32'd1);
      tick();
      check_val("c3_inst_valid", {31'd0, inst_valid}, 32'd1);
      check_val("c3_inst", inst, 32'h0000_0413);
      check_val("c3_pc", pc, 32'h8000_0000);
      check_val("c3_err", {31'd0, fetch_err}, 32'd0);
      tick();
      check_val("wb_inst_valid_low", {31'd0, inst_valid}, 32'd0);

      // Writeback to 0x8000_0010, then AR stalled for 4 cycles
      ar_ready = 1'b0;
      dnpc     = 32'h8000_0010;
      wb_valid = 1'b1;
      exp_ar.push_back(32'h8000_0010);
      tick();
      wb_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_val($sformatf("stall_ar_valid_%0d", i), {31'd0, ar_valid}, 32'd1);
         check_val($sformatf("stall_ar_addr_%0d", i), ar_addr, 32'h8000_0010);
         if (i == 4) begin
            ar_ready   = 1'b1;
            r_data     = 32'h00a0_0093;
            inst_ready = 1'b0;
            exp_inst.push_back('{inst: 32'h00a0_0093, pc: 32'h8000_0010, err: 1'b0});
         end
         tick();
      end
      check_val("stall_r_ready", {31'd0, r_ready}, 32'd1);
      check_val("stall_ar_hs", ar_hs, 32'd2);
      tick();

      // Decode back-pressure with a stray writeback pulse
      for (int j = 0; j < 3; j++) begin
         check_val($sformatf("bp_inst_valid_%0d", j), {31'd0, inst_valid}, 32'd1);
         check_val($sformatf("bp_inst_%0d", j), inst, 32'h00a0_0093);
         check_val($sformatf("bp_pc_%0d", j), pc, 32'h8000_0010);
         if (j == 1) begin
            wb_valid = 1'b1;
            dnpc     = 32'hDEAD_BEE0;
         end else begin
            wb_valid = 1'b0;
         end
         tick();
      end
      wb_valid   = 1'b0;
      inst_ready = 1'b1;
      tick();
      check_val("bp_done_inst_valid", {31'd0, inst_valid}, 32'd0);
      check_val("bp_pc_unmoved", pc, 32'h8000_0010);

      // Bus error response
      r_data   = 32'h1234_5678;
      r_resp   = 2'b10;
      dnpc     = 32'h8000_0020;
      wb_valid = 1'b1;
      exp_ar.push_back(32'h8000_0020);
      exp_inst.push_back('{inst: 32'h1234_5678, pc: 32'h8000_0020, err: 1'b1});
      tick();
      wb_valid = 1'b0;
      tick();
      tick();
      check_val("err_inst_valid", {31'd0, inst_valid}, 32'd1);
      check_val("err_fetch_err", {31'd0, fetch_err}, 32'd1);
      check_val("err_inst", inst, 32'h1234_5678);
      tick();

      // Misaligned dnpc: no bus read, fault word presented directly
      r_resp   = 2'b00;
      dnpc     = 32'h8000_0002;
      wb_valid = 1'b1;
      exp_inst.push_back('{inst: 32'h0000_0000, pc: 32'h8000_0002, err: 1'b1});
      tick();
      wb_valid = 1'b0;
      check_val("mis_ar_valid", {31'd0, ar_valid}, 32'd0);
      check_val("mis_inst_valid", {31'd0, inst_valid}, 32'd1);
      check_val("mis_inst", inst, 32'h0000_0000);
      check_val("mis_err", {31'd0, fetch_err}, 32'd1);
      check_val("mis_pc", pc, 32'h8000_0002);
      check_val("mis_ar_hs", ar_hs, 32'd3);
      tick();

      // Reset while waiting in RESP
      bus_go   = 1'b0;
      dnpc     = 32'h8000_0040;
      wb_valid = 1'b1;
      exp_ar.push_back(32'h8000_0040);
      tick();
      wb_valid = 1'b0;
      tick();
      check_val("rr_r_ready", {31'd0, r_ready}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      check_reset_values("async_rst");

      // First fetch after reset release restarts at RESET_PC
      r_data = 32'h0000_0513;
      exp_ar.push_back(32'h8000_0000);
      exp_inst.push_back('{inst: 32'h0000_0513, pc: 32'h8000_0000, err: 1'b0});
      @(negedge clk);
      bus_go = 1'b1;
      rst    = 1'b0;
      tick();
      check_val("rr_ar_valid", {31'd0, ar_valid}, 32'd1);
      check_val("rr_ar_addr", ar_addr, 32'h8000_0000);
      waited = 0;
      while (!inst_valid && waited < 10) begin
         tick();
         waited = waited + 1;
      end
      check_val("rr_inst_valid_timeout", {31'd0, inst_valid}, 32'd1);
      tick();

      // Every queued expectation must have been consumed
      check_val("sb_ar_drained", exp_ar.size(), 32'd0);
      check_val("sb_inst_drained", exp_inst.size(), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
